fetch_pc_gen: RTL and testbench
===============================

Name: fetch_pc_gen

Overview:
- Program-counter generator and instruction-fetch front end; feeds the decode/execute pipeline whose branch unit produces jb_enable/jb_target_pc.
- Holds the word-addressed PC and issues one fetch per cycle to a synchronous instruction memory (1-cycle read latency).
- Registers the returned instruction with its PC, absorbs downstream stalls with a 1-entry skid buffer, and redirects on a taken jump/branch, squashing fetches already in flight.

Parameters:
- RESET_PC, 32'h0, word address fetched first after reset.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- jb_enable  in  1  taken jump/branch pulse from branch unit
- jb_target_pc  in  32  redirect target, word address; valid when jb_enable=1
- stall  in  1  downstream cannot accept; inst_valid/inst_out/pc_out must hold
- imem_addr  out  32  word address to instruction memory (combinational from pc_reg)
- imem_rd  out  1  read strobe; data appears on imem_rdata the next cycle
- imem_rdata  in  32  instruction data, valid the cycle after an imem_rd
- inst_out  out  32  registered instruction to decode
- pc_out  out  32  word address of inst_out
- inst_valid  out  1  inst_out/pc_out valid
- flush  out  1  one-cycle pulse; decode/execute squash younger instructions

Behaviour:
- Reset (reset=1 at an edge): pc_reg=RESET_PC; inst_out=0; pc_out=0; inst_valid=0; flush=0; skid empty; in-flight flag cleared. While reset=1, imem_rd=0. Reset mid-operation discards in-flight fetch and skid contents.
- Issue: imem_rd = !reset & !stall. imem_addr=pc_reg. On issue, pc_reg <= pc_reg+1 (32-bit wrap 32'hFFFFFFFF -> 0). Record issued address and set in-flight flag for the next cycle.
- Return, cycle after issue: if in-flight is set and not squashed:
  - stall=0 and skid empty: inst_out<=imem_rdata, pc_out<=tagged address, inst_valid<=1.
  - stall=1: data goes to skid; outputs hold.
- Stall=1: pc_reg holds, no issue, and inst_out/pc_out/inst_valid hold.
- Stall release with skid full: output register loads skid (inst_valid=1). A new fetch is issued in the same cycle. Skid is empty afterwards.
- No return and no skid while stall=0: inst_valid<=0 (bubble).
- Redirect (jb_enable=1 at edge N):
  - pc_reg<=jb_target_pc.
  - Skid cleared; in-flight return arriving at N+1 discarded.
  - inst_valid=0 at N+1; flush=1 for cycle N+1 only.
  - The fetch issued in cycle N (old pc) is squashed.
- Redirect priority: jb_enable overrides stall. With stall=1 and jb_enable=1, pc_reg still loads the target, skid clears, inst_valid drops to 0.
- Back-to-back jb_enable: the latest target wins; flush stays asserted each following cycle.
- Timing: with no stall, the first fetch after reset deasserts is at cycle 0 (imem_addr=RESET_PC). imem_rdata arrives cycle 1; inst_valid=1 at cycle 2. Steady-state throughput is 1 instruction/cycle.
- Redirect-to-valid latency: 3 edges (target issued N+1, data N+2, inst_valid at N+3).

Test Plan:
- Reset release, stall=0, mem[i]=i+32'h100 -> imem_addr 0,1,2…; inst_valid rises at cycle 2 with pc_out=0, inst_out=32'h100, then increments every cycle.
- stall high for 3 cycles at pc_out=5 -> inst_out/pc_out hold 5. Skid captures pc 6. On release, pc 6 then 7 are delivered consecutively with no loss or duplication.
- jb_enable with jb_target_pc=32'h40 while streaming -> flush=1 for exactly one cycle, inst_valid=0 for 2 cycles. Next valid has pc_out=32'h40; stale pc never appears.
- jb_enable during stall with skid full, target=32'h80 -> skid dropped, inst_valid=0. After stall release, first valid pc_out=32'h80.
- Reset pulse mid-stream, with skid full and fetch in flight -> all outputs 0 next cycle. Restart from RESET_PC with no stale instruction.
- RESET_PC=32'hFFFFFFFE -> pc_out sequence FFFFFFFE, FFFFFFFF, 0, 1 (wrap).

Source files
------------

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
//   Program-counter generator and instruction-fetch front end. Issues one
//   word-addressed fetch per cycle to a synchronous instruction memory with a
//   1-cycle read latency. The returned instruction is registered together
//   with its PC. A 1-entry skid buffer absorbs the word that is still in
//   flight when a downstream stall begins. A taken jump/branch redirects the
//   PC, squashes the fetch in flight and pulses flush for one cycle.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   jb_enable     in   taken jump/branch pulse from the branch unit
//   jb_target_pc  in   [31:0] redirect target (word address)
//   stall         in   downstream cannot accept; outputs hold
//   imem_addr     out  [31:0] fetch address (driven directly from the PC)
//   imem_rd       out  read strobe; data returns on imem_rdata next cycle
//   imem_rdata    in   [31:0] instruction data returned by memory
//   inst_out      out  [31:0] registered instruction to decode
//   pc_out        out  [31:0] word address of inst_out
//   inst_valid    out  inst_out/pc_out are valid
//   flush         out  one-cycle squash pulse for decode/execute
// -----------------------------------------------------------------------------
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jb_enable,
  input  logic [31:0] jb_target_pc,
  input  logic        stall,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  output logic        flush
);

  // Control state (reset)
  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic        skid_valid_q, skid_valid_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;

  // Data-only state (no reset needed: always qualified by a valid flag)
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic issue;

  // Stage 0: issue to instruction memory
  assign issue     = !reset && !stall;
  assign imem_rd   = issue;
  assign imem_addr = pc_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = pc_q;
    skid_valid_d  = skid_valid_q;
    skid_inst_d   = skid_inst_q;
    skid_pc_d     = skid_pc_q;
    valid_d       = valid_q;
    inst_d        = inst_q;
    pc_out_d      = pc_out_q;
    flush_d       = jb_enable;

    if (jb_enable) begin
      // Redirect wins over stall. A fetch issued this cycle still carries
      // the old PC, so it is never marked in flight, and the word returning
      // this cycle is dropped along with the skid contents.
      pc_d         = jb_target_pc;
      skid_valid_d = 1'b0;
      valid_d      = 1'b0;
    end else begin
      if (issue) begin
        pc_d       = pc_q + 32'd1;
        inflight_d = 1'b1;
      end

      // Stage 1: memory return -> skid / output register
      if (stall) begin
        if (inflight_q) begin
          skid_valid_d = 1'b1;
          skid_inst_d  = imem_rdata;
          skid_pc_d    = inflight_pc_q;
        end
      end else if (skid_valid_q) begin
        // Nothing can be in flight here: the skid only fills on a stall
        // cycle, and stall cycles never issue.
        valid_d      = 1'b1;
        inst_d       = skid_inst_q;
        pc_out_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (inflight_q) begin
        valid_d  = 1'b1;
        inst_d   = imem_rdata;
        pc_out_d = inflight_pc_q;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Stage 2: output register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      flush_q      <= 1'b0;
      inst_q       <= 32'h0;
      pc_out_q     <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      skid_valid_q <= skid_valid_d;
      valid_q      <= valid_d;
      flush_q      <= flush_d;
      inst_q       <= inst_d;
      pc_out_q     <= pc_out_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    skid_inst_q   <= skid_inst_d;
    skid_pc_q     <= skid_pc_d;
  end

  assign inst_out   = inst_q;
  assign pc_out     = pc_out_q;
  assign inst_valid = valid_q;
  assign flush      = flush_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_gen
//   Directed and randomized bench for fetch_pc_gen. The reference model keeps
//   a queue of fetched-but-undelivered PCs, each tagged with its issue cycle;
//   a word can be delivered once a full cycle has passed since its issue.
//   A second instance with RESET_PC=32'hFFFFFFFE covers address wrap.
// -----------------------------------------------------------------------------
module tb_fetch_pc_gen;

  localparam logic [31:0] RST_PC  = 32'h0;
  localparam logic [31:0] WRAP_PC = 32'hFFFFFFFE;

  logic        clk;
  logic        reset, jb_enable, stall;
  logic [31:0] jb_target_pc;
  logic [31:0] imem_addr, imem_rdata, inst_out, pc_out;
  logic        imem_rd, inst_valid, flush;

  logic        reset2;
  logic [31:0] imem_addr2, imem_rdata2, inst_out2, pc_out2;
  logic        imem_rd2, inst_valid2, flush2;

  int compared   = 0;
  int mismatched = 0;

  fetch_pc_gen #(.RESET_PC(RST_PC)) u_dut (
    .clk(clk), .reset(reset), .jb_enable(jb_enable), .jb_target_pc(jb_target_pc),
    .stall(stall), .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid), .flush(flush)
  );

  fetch_pc_gen #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .reset(reset2), .jb_enable(1'b0), .jb_target_pc(32'h0),
    .stall(1'b0), .imem_addr(imem_addr2), .imem_rd(imem_rd2), .imem_rdata(imem_rdata2),
    .inst_out(inst_out2), .pc_out(pc_out2), .inst_valid(inst_valid2), .flush(flush2)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  // Synchronous instruction memories, 1-cycle latency; junk when not read.
  always @(posedge clk) begin
    imem_rdata  <= imem_rd  ? mem_word(imem_addr)  : $urandom();
    imem_rdata2 <= imem_rd2 ? mem_word(imem_addr2) : $urandom();
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cyc;
  } fetch_t;

  fetch_t      pend[$];
  logic [31:0] m_pc    = RST_PC;
  logic [31:0] cyc     = 0;
  logic        e_valid = 1'b0;
  logic        e_flush = 1'b0;
  logic [31:0] e_pc    = 0;
  logic [31:0] e_inst  = 0;

  task automatic model_step(input logic r, input logic j, input logic [31:0] t,
                            input logic s);
    fetch_t f;
    if (r) begin
      pend.delete();
      m_pc = RST_PC; e_valid = 0; e_flush = 0; e_pc = 0; e_inst = 0;
    end else if (j) begin
      pend.delete();
      m_pc = t; e_valid = 0; e_flush = 1;
    end else begin
      e_flush = 0;
      if (!s) begin
        if (pend.size() > 0 && pend[0].cyc < cyc) begin
          f = pend.pop_front();
          e_valid = 1; e_pc = f.pc; e_inst = mem_word(f.pc);
        end else begin
          e_valid = 0;
        end
        f.pc = m_pc; f.cyc = cyc;
        pend.push_back(f);
        m_pc = m_pc + 1;
      end
    end
    cyc = cyc + 1;
  endtask

  // ---------------- checking ----------------
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive, check fetch side mid-cycle, clock, check outputs.
  task automatic cycle(input logic r, input logic j, input logic [31:0] t, input logic s);
    reset = r; jb_enable = j; jb_target_pc = t; stall = s;
    @(negedge clk);
    check1("imem_rd", imem_rd, !r && !s);
    if (!r) check32("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    model_step(r, j, t, s);
    #1;
    check1("inst_valid", inst_valid, e_valid);
    check1("flush", flush, e_flush);
    if (e_valid) begin
      check32("pc_out", pc_out, e_pc);
      check32("inst_out", inst_out, e_inst);
    end
  endtask

  logic [31:0] wrap_exp [4];
  int          flush_cnt;

  initial begin
    reset = 1; jb_enable = 0; jb_target_pc = 0; stall = 0; reset2 = 1;
    wrap_exp[0] = 32'hFFFFFFFE; wrap_exp[1] = 32'hFFFFFFFF;
    wrap_exp[2] = 32'h0;        wrap_exp[3] = 32'h1;

    // Reset state
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check32("rst_pc_out", pc_out, 32'h0);
    check32("rst_inst_out", inst_out, 32'h0);
    check1("rst_valid", inst_valid, 1'b0);
    check1("rst_flush", flush, 1'b0);

    // Stream from reset; first valid at cycle 2 with pc 0 / inst 0x100
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check1("first_valid", inst_valid, 1'b1);
    check32("first_pc", pc_out, 32'h0);
    check32("first_inst", inst_out, 32'h100);
    for (int k = 0; k < 20 && !(e_valid && e_pc == 32'd5); k++) cycle(0, 0, 0, 0);
    check32("at_pc5", pc_out, 32'd5);

    // Stall 3 cycles holding pc 5, then pc 6 and 7 back to back
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 1);
      check32("stall_hold_pc", pc_out, 32'd5);
    end
    cycle(0, 0, 0, 0);
    check32("release_pc6", pc_out, 32'd6);
    cycle(0, 0, 0, 0);
    check32("release_pc7", pc_out, 32'd7);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);

    // Redirect to 0x40 while streaming
    cycle(0, 1, 32'h40, 0);
    flush_cnt = int'(flush);
    cycle(0, 0, 0, 0);
    flush_cnt += int'(flush);
    check1("jb_bubble2", inst_valid, 1'b0);
    cycle(0, 0, 0, 0);
    flush_cnt += int'(flush);
    check32("jb_flush_count", flush_cnt, 1);
    check32("jb_target_pc", pc_out, 32'h40);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);

    // Redirect during stall with a full skid
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h80, 1);
    check1("jb_stall_valid", inst_valid, 1'b0);
    cycle(0, 0, 0, 1);
    for (int k = 0; k < 10 && !e_valid; k++) cycle(0, 0, 0, 0);
    check32("jb_stall_first_pc", pc_out, 32'h80);

    // Back-to-back redirects: the latest target wins
    cycle(0, 1, 32'h200, 0);
    cycle(0, 1, 32'h300, 0);
    for (int k = 0; k < 10 && !e_valid; k++) cycle(0, 0, 0, 0);
    check32("b2b_first_pc", pc_out, 32'h300);

    // Reset pulse mid-stream with the skid full
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    check32("midrst_pc_out", pc_out, 32'h0);
    check32("midrst_inst_out", inst_out, 32'h0);
    check1("midrst_valid", inst_valid, 1'b0);
    check1("midrst_flush", flush, 1'b0);
    for (int k = 0; k < 10 && !e_valid; k++) cycle(0, 0, 0, 0);
    check32("midrst_first_pc", pc_out, RST_PC);

    // Wrap instance: main DUT idles under stall
    reset2 = 0;
    cycle(0, 0, 0, 1);
    check1("wrap_bubble", inst_valid2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 1);
      check1("wrap_valid", inst_valid2, 1'b1);
      check32("wrap_pc", pc_out2, wrap_exp[k]);
      check32("wrap_inst", inst_out2, mem_word(wrap_exp[k]));
    end
    reset2 = 1;

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic r, j, s;
      logic [31:0] t;
      r = ($urandom_range(0, 99) == 0);
      j = ($urandom_range(0, 99) < 6);
      s = ($urandom_range(0, 99) < 25);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - $urandom_range(0, 2)) : $urandom();
      cycle(r, j, t, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
